// File: rtl/pcie_arb_ctrl_if.sv
// Ingress-side bus of the PCIE VC arbiter: FIFO flags in, pop/push strobes and thresholds out.
interface pcie_arb_ctrl_if #(
  parameter int UMBRALES_L_H = 8
);
  logic                    init;
  logic [UMBRALES_L_H-1:0] umbral_L_in;
  logic [UMBRALES_L_H-1:0] umbral_H_in;
  logic [3:0]              in_empty;
  logic [7:0]              head_dest;
  logic [3:0]              out_almost_full;
  logic [7:0]              fifo_error;
  logic [3:0]              pop_in;
  logic [3:0]              push_out;
  logic [UMBRALES_L_H-1:0] umbral_L;
  logic [UMBRALES_L_H-1:0] umbral_H;
  logic [2:0]              state;
  logic                    idle;

  modport master (
    input  init, umbral_L_in, umbral_H_in, in_empty, head_dest, out_almost_full, fifo_error,
    output pop_in, push_out, umbral_L, umbral_H, state, idle
  );

  modport slave (
    output init, umbral_L_in, umbral_H_in, in_empty, head_dest, out_almost_full, fifo_error,
    input  pop_in, push_out, umbral_L, umbral_H, state, idle
  );
endinterface

// File: rtl/pcie_arb_ctrl.sv
// PCIE VC central controller: reset/init/idle/active FSM, threshold latch, 4:1 pop arbiter.
// Optional macro ARB_STRICT_PRIO_EN: fixed priority (input 0 highest) instead of round-robin.
module pcie_arb_lane (
  input  logic       empty,
  input  logic [1:0] dest,
  input  logic [3:0] almost_full,
  input  logic       popped,
  output logic       elig
);
  // popped: empty flag lags the pop by one edge, so skip a lane right after its pop
  assign elig = !empty && !almost_full[dest] && !popped;
endmodule

module pcie_arb_ctrl #(
  parameter int UMBRALES_L_H = 8
) (
  input  logic            clk,
  input  logic            reset,
  pcie_arb_ctrl_if.master bus
);
  localparam int NUM_LANES = 4;
  localparam logic [NUM_LANES-1:0] ONE = NUM_LANES'(1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [NUM_LANES-1:0]       pop_q, push_q, elig;
  logic [NUM_LANES-1:0][1:0]  lane_dest;
  logic [UMBRALES_L_H-1:0]    hold_l, hold_h, thr_l, thr_h;
  logic                       infl_vld;
  logic [1:0]                 infl_dest;
  logic                       gnt_vld;
  logic [1:0]                 gnt_idx, idx;
  logic                       run, take;
`ifndef ARB_STRICT_PRIO_EN
  logic [1:0]                 rr_ptr;
`endif

  assign lane_dest = bus.head_dest;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      pcie_arb_lane u_lane (
        .empty       (bus.in_empty[g]),
        .dest        (lane_dest[g]),
        .almost_full (bus.out_almost_full),
        .popped      (pop_q[g]),
        .elig        (elig[g])
      );
    end
  endgenerate

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
`ifdef ARB_STRICT_PRIO_EN
      idx = 2'(k);
`else
      idx = rr_ptr + 2'(k);
`endif
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   if (!bus.init) state_d = S_IDLE;
      S_IDLE:   if (bus.in_empty != '1) state_d = S_ACTIVE;
      S_ACTIVE: if (bus.in_empty == '1 && pop_q == '0 && push_q == '0) state_d = S_IDLE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_RESET;
    endcase
    // init outranks error; neither applies while still leaving reset
    if (state_q != S_RESET) begin
      if (bus.init)                                 state_d = S_INIT;
      else if (|bus.fifo_error && state_q != S_INIT) state_d = S_ERROR;
    end
  end

  // strobes only move while we stay in ACTIVE; leaving it drops the in-flight word
  assign run  = (state_q == S_ACTIVE) && (state_d == S_ACTIVE);
  assign take = run && gnt_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_q     <= '0;
      push_q    <= '0;
      hold_l    <= '0;
      hold_h    <= '0;
      thr_l     <= '0;
      thr_h     <= '0;
      infl_vld  <= 1'b0;
      infl_dest <= '0;
`ifndef ARB_STRICT_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      if (state_q == S_INIT && bus.init) begin
        hold_l <= bus.umbral_L_in;
        hold_h <= bus.umbral_H_in;
      end
      if (state_q == S_INIT && state_d == S_IDLE) begin
        thr_l <= hold_l;
        thr_h <= hold_h;
      end
      pop_q    <= take ? (ONE << gnt_idx) : '0;
      push_q   <= (run && infl_vld) ? (ONE << infl_dest) : '0;
      infl_vld <= take;
      if (take) begin
        infl_dest <= lane_dest[gnt_idx];
`ifndef ARB_STRICT_PRIO_EN
        rr_ptr    <= gnt_idx + 2'd1;
`endif
      end
    end
  end

  assign bus.pop_in   = pop_q;
  assign bus.push_out = push_q;
  assign bus.umbral_L = thr_l;
  assign bus.umbral_H = thr_h;
  assign bus.state    = state_q;
  assign bus.idle     = (state_q == S_IDLE);
endmodule

// File: tb/tb_pcie_arb_ctrl.sv
// Directed bench for pcie_arb_ctrl (round-robin build): config, RR, backpressure, single source, error.
module tb_pcie_arb_ctrl;
  logic clk;
  logic reset;
  int   n_asrt;
  int   n_fail;

  pcie_arb_ctrl_if #(.UMBRALES_L_H(8)) bus ();

  pcie_arb_ctrl #(.UMBRALES_L_H(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic [2:0] st, input logic [3:0] pop,
                         input logic [3:0] push);
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".pop"},   32'(bus.pop_in), 32'(pop));
    chk({tag, ".push"},  32'(bus.push_out), 32'(push));
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    reset               = 1'b0;
    bus.init            = 1'b0;
    bus.umbral_L_in     = 8'd0;
    bus.umbral_H_in     = 8'd0;
    bus.in_empty        = 4'hF;
    bus.head_dest       = 8'h00;
    bus.out_almost_full = 4'h0;
    bus.fifo_error      = 8'h00;
    tick();
    tick();
    exp_out("rst", 3'd0, 4'h0, 4'h0);
    chk("rst.L", 32'(bus.umbral_L), 32'd0);
    chk("rst.H", 32'(bus.umbral_H), 32'd0);
    chk("rst.idle", 32'(bus.idle), 32'd0);

    // reset release and threshold configuration
    reset = 1'b1; bus.init = 1'b1; bus.umbral_L_in = 8'd1; bus.umbral_H_in = 8'd5;
    tick(); exp_out("cfg1", 3'd1, 4'h0, 4'h0);
    tick(); exp_out("cfg2", 3'd1, 4'h0, 4'h0);
    chk("cfg2.L", 32'(bus.umbral_L), 32'd0);
    bus.init = 1'b0;
    tick(); exp_out("cfg3", 3'd2, 4'h0, 4'h0);
    chk("cfg3.L", 32'(bus.umbral_L), 32'd1);
    chk("cfg3.H", 32'(bus.umbral_H), 32'd5);
    chk("cfg3.idle", 32'(bus.idle), 32'd1);

    // round-robin: input i -> destination 3-i
    bus.in_empty = 4'h0; bus.head_dest = 8'h1B;
    tick(); exp_out("rrA", 3'd3, 4'h0, 4'h0);
    tick(); exp_out("rrB", 3'd3, 4'b0001, 4'h0);
    tick(); exp_out("rrC", 3'd3, 4'b0010, 4'b1000);
    tick(); exp_out("rrD", 3'd3, 4'b0100, 4'b0100);
    tick(); exp_out("rrE", 3'd3, 4'b1000, 4'b0010);
    tick(); exp_out("rrF", 3'd3, 4'b0001, 4'b0001);
    tick(); exp_out("rrG", 3'd3, 4'b0010, 4'b1000);

    // backpressure: inputs 0,1 both to destination 0, which is almost full
    bus.in_empty = 4'b1100; bus.head_dest = 8'h00; bus.out_almost_full = 4'b0001;
    tick(); exp_out("bpH", 3'd3, 4'h0, 4'b0100);
    tick(); exp_out("bpI", 3'd3, 4'h0, 4'h0);
    tick(); exp_out("bpJ", 3'd3, 4'h0, 4'h0);
    bus.out_almost_full = 4'h0;
    tick(); exp_out("bpK", 3'd3, 4'b0001, 4'h0);
    tick(); exp_out("bpL", 3'd3, 4'b0010, 4'b0001);
    tick(); exp_out("bpM", 3'd3, 4'b0001, 4'b0001);
    bus.in_empty = 4'hF;
    tick(); exp_out("drN", 3'd3, 4'h0, 4'b0001);
    tick(); exp_out("drO", 3'd3, 4'h0, 4'h0);
    tick(); exp_out("drP", 3'd2, 4'h0, 4'h0);

    // single source: input 2 holds 3 words for destination 3
    bus.in_empty = 4'b1011; bus.head_dest = 8'h30;
    tick(); exp_out("ssQ", 3'd3, 4'h0, 4'h0);
    tick(); exp_out("ssR", 3'd3, 4'b0100, 4'h0);
    tick(); exp_out("ssS", 3'd3, 4'h0, 4'b1000);
    tick(); exp_out("ssT", 3'd3, 4'b0100, 4'h0);
    tick(); exp_out("ssU", 3'd3, 4'h0, 4'b1000);
    tick(); exp_out("ssV", 3'd3, 4'b0100, 4'h0);
    tick(); exp_out("ssW", 3'd3, 4'h0, 4'b1000);
    bus.in_empty = 4'hF;
    tick(); exp_out("ssX", 3'd3, 4'h0, 4'h0);
    tick(); exp_out("ssY", 3'd2, 4'h0, 4'h0);

    // error during traffic drops the in-flight push
    bus.in_empty = 4'b1110; bus.head_dest = 8'h01;
    tick(); exp_out("erZ1", 3'd3, 4'h0, 4'h0);
    tick(); exp_out("erZ2", 3'd3, 4'b0001, 4'h0);
    bus.fifo_error = 8'h20;
    tick(); exp_out("erZ3", 3'd4, 4'h0, 4'h0);
    tick(); exp_out("erZ4", 3'd4, 4'h0, 4'h0);
    bus.fifo_error = 8'h00;
    tick(); exp_out("erZ5", 3'd4, 4'h0, 4'h0);
    bus.init = 1'b1; bus.umbral_L_in = 8'd2; bus.umbral_H_in = 8'd6;
    tick(); exp_out("erZ6", 3'd1, 4'h0, 4'h0);
    chk("erZ6.L", 32'(bus.umbral_L), 32'd1);
    tick(); exp_out("erZ7", 3'd1, 4'h0, 4'h0);
    bus.init = 1'b0;
    tick(); exp_out("erZ8", 3'd2, 4'h0, 4'h0);
    chk("erZ8.L", 32'(bus.umbral_L), 32'd2);
    chk("erZ8.H", 32'(bus.umbral_H), 32'd6);
    tick(); exp_out("erZ9", 3'd3, 4'h0, 4'h0);

    // init outranks a simultaneous error
    bus.init = 1'b1; bus.fifo_error = 8'h01;
    tick(); exp_out("prZ10", 3'd1, 4'h0, 4'h0);
    bus.init = 1'b0; bus.fifo_error = 8'h00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/pcie_arb_ctrl.md
# pcie_arb_ctrl

Central controller for the PCIE virtual-channel datapath. Sequences the reset/init/idle/active flow, latches and distributes the almost-full/almost-empty thresholds to the FIFOs, and arbitrates pops from the four input FIFOs into the destination demux. It stops traffic toward any output FIFO (FIFO4–FIFO7) that reports almost-full. The block sits between the input FIFO bank and the demux/output FIFO bank and drives every FIFO pop/push strobe on the ingress side.

## Interface
- UMBRALES_L_H, 8, width of threshold registers
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- init  in  1  configuration request; thresholds sampled while high
- umbral_L_in  in  UMBRALES_L_H  requested almost-empty threshold
- umbral_H_in  in  UMBRALES_L_H  requested almost-full threshold
- in_empty  in  4  empty flags of input FIFOs 0–3
- head_dest  in  8  2-bit destination of each input FIFO head; bits [2i+1:2i] belong to FIFO i
- out_almost_full  in  4  almost-full flags of output FIFOs 4–7; bit d is FIFO 4+d
- fifo_error  in  8  overflow/underflow flags of all eight FIFOs
- pop_in  out  4  one-hot pop to input FIFOs, registered
- push_out  out  4  one-hot push to output FIFOs, registered
- umbral_L  out  UMBRALES_L_H  active almost-empty threshold to all FIFOs
- umbral_H  out  UMBRALES_L_H  active almost-full threshold to all FIFOs
- state  out  3  current state code
- idle  out  1  high when state is IDLE

## Operation
- States and codes: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- Asynchronous reset (reset=0) forces:
  - state RESET
  - pop_in=0, push_out=0
  - umbral_L=0, umbral_H=0
  - idle=0
  - RR pointer=0, in-flight register cleared
- RESET → INIT on the first edge with reset=1.
- INIT:
  - Each edge with init=1 copies umbral_L_in/umbral_H_in into holding registers.
  - INIT → IDLE on the first edge with init=0. On that edge the holding registers are transferred to umbral_L/umbral_H.
- IDLE → ACTIVE when any in_empty bit is 0.
- ACTIVE → IDLE when in_empty=4'hF, pop_in=0 and push_out=0.
- Any state except RESET → INIT when init=1. INIT has priority over ERROR entry.
- Any state except RESET/INIT → ERROR when any fifo_error bit is 1.
  - ERROR holds pop_in=0 and push_out=0.
  - ERROR exits only through reset or init.
- Arbitration runs in ACTIVE only. Input i is eligible when all of the following hold:
  - in_empty[i]=0
  - out_almost_full[head_dest[i]]=0
  - pop_in[i]=0 in the current cycle (one-cycle blackout, because the empty flag lags the pop by one edge)
- At most one grant per edge.
  - Round-robin search starts at the RR pointer and proceeds i, i+1, …, wrapping from 3 to 0.
  - After a grant to input g, the pointer becomes (g+1) mod 4. With no grant, the pointer holds.
- The granted input's destination d is captured in the in-flight register. push_out[d] is asserted on the following edge.

## Timing
- Grant decided at edge k from inputs sampled at k.
- pop_in[g] is high for exactly one cycle, from k to k+1.
- push_out[d] is high for exactly one cycle, from k+1 to k+2. This aligns with the FIFO's one-cycle read latency.
- Back-to-back grants to different inputs are allowed every cycle, so sustained throughput is 1 word/cycle.
- A single input is served at most every other cycle.
- out_almost_full is sampled at the decision edge only. Up to 2 words may still land in an output FIFO after its almost-full assertion, so umbral_H must leave at least 2 entries of headroom.
- Leaving ACTIVE for INIT or ERROR while a push is in flight: push_out is forced to 0 and the in-flight word is dropped.
- Thresholds change only on the INIT→IDLE edge and never during traffic.

## Configuration
- ARB_STRICT_PRIO_EN defined: the RR pointer is removed. The lowest-index eligible input always wins (FIFO0 highest priority), and the blackout rule still applies.
- ARB_STRICT_PRIO_EN undefined: round-robin as specified above.

## Test plan
- Reset/config:
  - Stimulus: reset=0, release, init=1 with L=1/H=5, then init=0.
  - Required: state goes 0→1→2; umbral_L=1 and umbral_H=5 appear on the INIT→IDLE edge; all strobes stay 0.
- Round-robin:
  - Stimulus: all four inputs non-empty with distinct destinations, no almost-full.
  - Required: pop_in sequence 0001, 0010, 0100, 1000, 0001; each push_out one cycle later to the matching destination.
- Backpressure:
  - Stimulus: out_almost_full=4'b0001; inputs 0 and 1 both target destination 0.
  - Required: no pop_in to either input and no push_out[0] until the flag clears, then service resumes at the pointer position.
- Single source:
  - Stimulus: only input 2 non-empty, with 3 words.
  - Required: pop_in=0100 on alternate cycles; ACTIVE→IDLE two cycles after the last pop.
- Error:
  - Stimulus: fifo_error[5]=1 during traffic.
  - Required: state=4, strobes 0 on the next edge, in-flight push dropped; init=1 returns to INIT.
- Strict priority (ARB_STRICT_PRIO_EN):
  - Stimulus: inputs 0 and 3 continuously non-empty.
  - Required: input 0 granted on every eligible cycle; input 3 granted only in input 0's blackout cycles.
